// File: rtl/ram32_arbiter_pkg.sv
// rtl/ram32_arbiter_pkg.sv - shared widths, FSM states and request bundle for the RAM32 arbiter
package ram32_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOCK0 = 2'd2,
    LOCK1 = 2'd3
  } state_t;

  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
  } req_t;

endpackage

// File: rtl/ram32_arbiter_grant.sv
// rtl/ram32_arbiter_grant.sv - combinational two-port grant; RAM32_ARBITER_ROUND_ROBIN_EN adds a priority pointer
module ram32_arbiter_grant
  import ram32_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  state_t     state,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] grant
);

  logic ptr;

`ifdef RAM32_ARBITER_ROUND_ROBIN_EN
  // Pointer only advances on unlocked beats taken from IDLE, so it is frozen across a lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (state == IDLE && |(grant & ~lock)) begin
      ptr <= ~ptr;
    end
  end
`else
  logic unused;
  assign ptr    = 1'b0;
  assign unused = &{1'b0, clk, rst_n, lock};
`endif

  always_comb begin
    grant = 2'b00;
    case (state)
      IDLE: begin
        if (valid[0] && valid[1]) begin
          grant = ptr ? 2'b10 : 2'b01;
        end else begin
          grant = valid;
        end
      end
      LOCK0:   grant[0] = valid[0];
      LOCK1:   grant[1] = valid[1];
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram32_arbiter.sv
// rtl/ram32_arbiter.sv - clears then shares one RAM32 macro between two ports; RAM32_ARBITER_ROUND_ROBIN_EN selects round-robin priority
module ram32_arbiter
  import ram32_arbiter_pkg::*;
#(
  parameter int                WORDS       = 32,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [BE_W-1:0]   p0_be,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [BE_W-1:0]   p1_be,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_a,
  output logic [BE_W-1:0]   ram_we,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do,
  output logic              init_done
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rsp_pend;
  logic              rsp_port;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              accept;
  logic              port;
  req_t              req0, req1, sel;

  assign req0 = '{be: p0_be, addr: p0_addr, wdata: p0_wdata, lock: p0_lock};
  assign req1 = '{be: p1_be, addr: p1_addr, wdata: p1_wdata, lock: p1_lock};

  ram32_arbiter_grant u_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .state (state),
    .valid ({p1_valid, p0_valid}),
    .lock  ({p1_lock, p0_lock}),
    .grant (grant)
  );

  // Outputs are gated by rst_n so a reset cycle kills a response that was already in flight.
  assign ready  = grant & {2{rst_n}};
  assign accept = |ready;
  assign port   = ready[1];
  assign sel    = port ? req1 : req0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      rsp_pend <= 1'b0;
      rsp_port <= 1'b0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end
      rsp_pend <= accept;
      rsp_port <= port;
    end
  end

  always_comb begin
    state_next = state;
    ram_en     = 1'b0;
    ram_a      = '0;
    ram_we     = '0;
    ram_di     = '0;
    case (state)
      CLEAR: begin
        ram_en = 1'b1;
        ram_we = '1;
        ram_a  = clr_cnt;
        ram_di = CLEAR_VALUE;
        if (clr_cnt == ADDR_W'(WORDS - 1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        if (accept) begin
          ram_en     = 1'b1;
          ram_a      = sel.addr;
          ram_we     = sel.be;
          ram_di     = sel.wdata;
          state_next = sel.lock ? (port ? LOCK1 : LOCK0) : IDLE;
        end
      end
    endcase
    if (!rst_n) begin
      ram_en = 1'b0;
      ram_we = '0;
    end
  end

  assign p0_ready     = ready[0];
  assign p1_ready     = ready[1];
  assign p0_rsp_valid = rst_n & rsp_pend & ~rsp_port;
  assign p1_rsp_valid = rst_n & rsp_pend & rsp_port;
  assign p0_rsp_rdata = ram_do;
  assign p1_rsp_rdata = ram_do;
  assign init_done    = rst_n && (state != CLEAR);

endmodule

// File: doc/ram32_arbiter.md
# ram32_arbiter

Shares one RAM32 macro (32 words × 32 bit, 4 byte-lanes, 1-cycle synchronous read) between two requester ports. After reset it zero-fills the macro, then arbitrates single-beat and locked multi-beat transactions. Each accepted transaction returns exactly one response one cycle later. It sits between the top-level host/pin logic and the RAM32 instance, and owns the macro's EN/A/WE/Di pins exclusively.

## Interface
- `WORDS`, default 32: depth cleared after reset; must equal the macro depth.
- `CLEAR_VALUE`, default 32'h0: word written during clear.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low. Clock is `clk`.
- `pN_valid`, in, 1 (N=0,1): request valid. It must not depend on `pN_ready`.
- `pN_ready`, out, 1: request accepted this cycle when valid&&ready.
- `pN_be`, in, 4: byte write enables. 4'h0 means a read.
- `pN_addr`, in, 5: word address.
- `pN_wdata`, in, 32: write data, byte-lane aligned.
- `pN_lock`, in, 1: hold the grant after this beat.
- `pN_rsp_valid`, out, 1: response strobe. It has no backpressure.
- `pN_rsp_rdata`, out, 32: read data. Valid with rsp_valid for reads.
- `ram_en`, out, 1: to RAM32 EN0.
- `ram_a`, out, 5: to RAM32 A0.
- `ram_we`, out, 4: to RAM32 WE0.
- `ram_di`, out, 32: to RAM32 Di0.
- `ram_do`, in, 32: from RAM32 Do0.
- `init_done`, out, 1: clear finished; ports are open.

## Operation
- **States:** CLEAR, IDLE, LOCK0, LOCK1.
- **Reset:** while rst_n=0:
  - state←CLEAR, clear counter←0.
  - ram_en=0, all readies 0, rsp_valid 0, init_done 0.
  - Any in-flight response is dropped.
- **CLEAR:**
  - Each cycle drive ram_en=1, ram_we=4'hF, ram_a=counter, ram_di=CLEAR_VALUE, then increment the counter.
  - After writing word WORDS-1, go to IDLE and set init_done=1.
  - Readies are 0 throughout.
- **IDLE, grant selection:** combinational.
  - If only one port is valid, grant that port.
  - If both are valid, grant the port chosen by priority (see Configuration).
  - Granted port: ready=1. Other port: ready=0.
- **Accept:** drive ram_en=1, ram_a=addr, ram_we=be, ram_di=wdata of the granted port. With no accept, ram_en=0 and ram_we=0.
- **Lock:**
  - An accepted beat with lock=1 moves the state to LOCKn.
  - In LOCKn only port n may be ready, even when it is idle. Port n's ready is 1 whenever it is valid.
  - An accepted beat with lock=0 returns the state to IDLE.
- **Response:**
  - Register the accepting port ID and an accept flag.
  - The next cycle, assert that port's rsp_valid for one cycle, for reads and writes alike.
  - rsp_rdata = ram_do for both ports (pass-through). The value is meaningful only for read responses.
- Address and byte-enable values are passed through unchanged; there is no width arithmetic. Word index wraps naturally at 5 bits.

## Timing
- Grant and ready are combinational from valid and state. The macro sees the request in the accept cycle.
- Response latency is exactly 1 cycle after accept. Throughput is 1 transaction per cycle with no bubbles.
- A read of an address written in the previous cycle returns the new data (macro write-then-read).
- Clear takes WORDS cycles after rst_n rises. With the default, init_done rises in the 33rd cycle after reset release.
- Reset asserted mid-lock or mid-clear takes priority: the next state is CLEAR and the counter restarts at 0.
- Back-to-back accepts from alternating ports give alternating rsp_valid strobes with no gap.

## Configuration
- Macro: `RAM32_ARBITER_ROUND_ROBIN_EN`.
- **Defined:** a 1-bit priority pointer, reset to port 0.
  - After each accepted beat with lock=0, the pointer moves to the other port.
  - Under contention the port named by the pointer wins.
  - The pointer is frozen while in LOCK states.
- **Undefined:** fixed priority, where port 0 always wins contention. No pointer flop exists.

## Structure
- Package `ram32_arbiter_pkg` holds:
  - ADDR_W=5, DATA_W=32, BE_W=4 constants.
  - The state enum type (CLEAR/IDLE/LOCK0/LOCK1).
  - The request struct {be, addr, wdata, lock}.
- Sub-module `ram32_arbiter_grant`: combinational grant plus the round-robin pointer flop when the macro is defined. The top module holds the FSM, clear counter, response register and RAM muxing.

## Test plan
- **Reset release:** ram_we=4'hF with addresses 0..31 on consecutive cycles; init_done=1 after 32 cycles. Reading word 7 from p0 then gives rsp_rdata=32'h0.
- **Byte write:** p0 writes be=4'h2, addr=5, wdata=32'h0000AB00, then reads addr 5 → rsp_rdata=32'h0000AB00 one cycle after accept, on p0 only.
- **Contention:** p0 and p1 both hold valid reads for 4 cycles.
  - Macro defined: grants p0,p1,p0,p1.
  - Macro undefined: grants p0,p0,p0,p0, and p1_ready stays 0.
- **Lock:** p1 issues 3 beats with lock=1,1,0 while p0 stays valid. p0_ready=0 until p1's lock=0 beat is accepted; p0 is granted the next cycle.
- **Reset mid-operation:** assert rst_n=0 on the cycle after a read accept. No rsp_valid fires, clear restarts at address 0, and init_done drops to 0.
